// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-2^K multiplier.
// Holds the FSM state enum, the counter-width helper and the default sizes.
// Optional build macro used by the design: SEQ_MULT_SIGNED_EN.
package mult_pkg;

  localparam int unsigned MULT_N_DEF = 256;
  localparam int unsigned MULT_K_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Width of the digit counter: enough to index N/K digits.
  function automatic int unsigned mult_cnt_width(input int unsigned n, input int unsigned k);
    return $clog2(n / k);
  endfunction

endpackage

// File: rtl/mult_pp_digit.sv
// Partial product of the multiplicand with one K-bit multiplier digit.
// Ports:
//   a     - N-bit multiplicand
//   digit - K-bit multiplier digit
//   sgn   - (SEQ_MULT_SIGNED_EN only) operands are two's complement
//   top   - (SEQ_MULT_SIGNED_EN only) digit is the most significant one
//   pp    - N+K+1 bit partial product (two's complement when signed)
// Build macro: SEQ_MULT_SIGNED_EN enables the signed variant.
module mult_pp_digit #(
  parameter int unsigned N = 256,
  parameter int unsigned K = 4
) (
  input  logic [N-1:0] a,
  input  logic [K-1:0] digit,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic         sgn,
  input  logic         top,
`endif
  output logic [N+K:0] pp
);

  localparam int unsigned PW = N + K + 1;

`ifdef SEQ_MULT_SIGNED_EN
  logic signed [PW-1:0] a_w;
  logic signed [PW-1:0] d_w;

  // a is sign-extended when signed; only the top digit of b carries sign weight.
  assign a_w = PW'($signed({sgn & a[N-1], a}));
  assign d_w = PW'($signed({sgn & top & digit[K-1], digit}));
  assign pp  = a_w * d_w;
`else
  assign pp = PW'(a) * PW'(digit);
`endif

endmodule

// File: rtl/seq_mult_radix.sv
// Sequential multiplier retiring K multiplier bits per cycle.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid, in_ready  - operand handshake (a, b captured on accept)
//   sgn                 - (SEQ_MULT_SIGNED_EN only) signed operation select
//   abort               - cancel an operation while BUSY
//   out_valid, out_ready- result handshake
//   prod                - 2N-bit product, held while out_valid
//   acc                 - live accumulator (low 2N bits), debug only
//   busy                - multiplication in progress
// Build macro: SEQ_MULT_SIGNED_EN adds the sgn input and signed products.
module seq_mult_radix
  import mult_pkg::*;
#(
  parameter int unsigned N = MULT_N_DEF,
  parameter int unsigned K = MULT_K_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic           sgn,
`endif
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] prod,
  output logic [2*N-1:0] acc,
  output logic           busy
);

  localparam int unsigned AW   = 2 * N + K;
  localparam int unsigned PW   = N + K + 1;
  localparam int unsigned CWR  = mult_cnt_width(N, K);
  localparam int unsigned CW   = (CWR == 0) ? 1 : CWR;
  localparam int unsigned LAST = N / K - 1;

  mult_state_t state_q, state_d;

  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] acc_q;
  logic [PW-1:0] pp;
  logic [AW-1:0] pp_ext;
  logic [AW-1:0] acc_next;
  logic [31:0]   shamt;
  logic          last_digit;
`ifdef SEQ_MULT_SIGNED_EN
  logic          sgn_q;
`endif

  // b_q is shifted right each BUSY cycle, so its low K bits are always the current digit.
  mult_pp_digit #(.N(N), .K(K)) u_pp (
    .a     (a_q),
    .digit (b_q[K-1:0]),
`ifdef SEQ_MULT_SIGNED_EN
    .sgn   (sgn_q),
    .top   (last_digit),
`endif
    .pp    (pp)
  );

  assign last_digit = (cnt_q == CW'(LAST));
  assign shamt      = 32'(cnt_q) * 32'(K);
  assign pp_ext     = {{(AW-PW){pp[PW-1]}}, pp};
  assign acc_next   = acc_q + (pp_ext << shamt);
  assign acc        = acc_q[2*N-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: begin
        if (abort)           state_d = IDLE;
        else if (last_digit) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand capture, digit counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      prod  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sgn_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            cnt_q <= '0;
            acc_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sgn_q <= sgn;
`endif
          end
        end
        BUSY: begin
          if (abort) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else begin
            acc_q <= acc_next;
            b_q   <= b_q >> K;
            if (last_digit) begin
              prod  <= acc_next[2*N-1:0];
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
